// File: rtl/ewrapper_emesh_rx_buffer.sv
// ---------------------------------------------------------------------------
// ewrapper_emesh_rx_buffer
//
// Purpose:
//   Receive-side buffer for the emesh link. Incoming transactions are sorted
//   into a write queue and a read queue. Each queue is drained through a
//   valid/ready interface. Each queue drives its own registered wait signal
//   back to the link. Wait rises while SKID free entries still remain, which
//   absorbs the transactions the link keeps sending after wait is raised.
//
// Ports:
//   emesh_clk_inb          link receive clock (the only clock)
//   reset                  asynchronous, active-high
//   emesh_*_inb            incoming transaction (access strobe plus fields)
//   emesh_wr_wait_outb     back-pressure for writes (1 while in reset)
//   emesh_rd_wait_outb     back-pressure for reads  (1 while in reset)
//   wr_valid/wr_ready      write queue head handshake
//   wr_dstaddr, wr_data, wr_datamode, wr_ctrlmode
//                          write head payload (show-ahead, 0 while empty)
//   rd_valid/rd_ready      read queue head handshake
//   rd_dstaddr, rd_srcaddr, rd_datamode, rd_ctrlmode
//                          read head payload (show-ahead, 0 while empty)
//   wr_overflow            sticky: a write was dropped because the queue was full
//   rd_overflow            sticky: a read was dropped because the queue was full
// ---------------------------------------------------------------------------

// Circular-buffer queue with show-ahead head, a registered threshold wait,
// and a sticky overflow flag.
module ewrapper_emesh_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int SKID  = 4,
   parameter int W     = 70
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_wait,
   output logic         o_overflow
);

   localparam logic [AW:0] LP_FULL   = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_THRESH = (AW+1)'(DEPTH - SKID);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          r_wait;
   logic          r_overflow;

   logic          w_pop;
   logic          w_push_ok;
   logic          w_drop;
   logic [AW:0]   w_count_nxt;

   // A full queue still accepts a push when its head leaves in the same
   // cycle. The incoming entry lands in the slot being vacated.
   always_comb begin
      w_pop       = (r_count != '0) && i_ready;
      w_push_ok   = i_push && ((r_count < LP_FULL) || w_pop);
      w_drop      = i_push && !w_push_ok;
      w_count_nxt = r_count;
      if (w_push_ok && !w_pop)
         w_count_nxt = r_count + 1'b1;
      else if (!w_push_ok && w_pop)
         w_count_nxt = r_count - 1'b1;
   end

   // Wait comes up during reset so that the link is held off until the
   // first clock edge after release.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_wait     <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         r_count <= w_count_nxt;
         r_wait  <= (w_count_nxt >= LP_THRESH);
         if (w_drop)
            r_overflow <= 1'b1;
      end
   end

   // The storage array has no reset. Contents are meaningless once the
   // pointers and count are cleared.
   always_ff @(posedge i_clk) begin
      if (w_push_ok)
         r_mem[r_wptr] <= i_data;
   end

   // The head is forced to zero while the queue is empty. This also
   // produces the all-zero payload required during reset.
   assign o_valid    = (r_count != '0);
   assign o_data     = o_valid ? r_mem[r_rptr] : '0;
   assign o_wait     = r_wait;
   assign o_overflow = r_overflow;

endmodule

module ewrapper_emesh_rx_buffer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int SKID  = 4
) (
   input  logic        emesh_clk_inb,
   input  logic        reset,
   input  logic        emesh_access_inb,
   input  logic        emesh_write_inb,
   input  logic [1:0]  emesh_datamode_inb,
   input  logic [3:0]  emesh_ctrlmode_inb,
   input  logic [31:0] emesh_dstaddr_inb,
   input  logic [31:0] emesh_srcaddr_inb,
   input  logic [31:0] emesh_data_inb,
   output logic        emesh_wr_wait_outb,
   output logic        emesh_rd_wait_outb,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [31:0] wr_dstaddr,
   output logic [31:0] wr_data,
   output logic [1:0]  wr_datamode,
   output logic [3:0]  wr_ctrlmode,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_dstaddr,
   output logic [31:0] rd_srcaddr,
   output logic [1:0]  rd_datamode,
   output logic [3:0]  rd_ctrlmode,
   output logic        wr_overflow,
   output logic        rd_overflow
);

   localparam int LP_EW = 70;

   logic             w_wr_push;
   logic             w_rd_push;
   logic [LP_EW-1:0] w_wr_entry;
   logic [LP_EW-1:0] w_rd_entry;
   logic [LP_EW-1:0] w_wr_head;
   logic [LP_EW-1:0] w_rd_head;

   // Only one transaction arrives per cycle. It goes to exactly one queue.
   // Writes keep their data and reads keep their return address. The field
   // that the other kind of transaction would need is dropped.
   assign w_wr_push  = emesh_access_inb &  emesh_write_inb;
   assign w_rd_push  = emesh_access_inb & ~emesh_write_inb;
   assign w_wr_entry = {emesh_dstaddr_inb, emesh_data_inb,
                        emesh_datamode_inb, emesh_ctrlmode_inb};
   assign w_rd_entry = {emesh_dstaddr_inb, emesh_srcaddr_inb,
                        emesh_datamode_inb, emesh_ctrlmode_inb};

   ewrapper_emesh_rx_fifo #(
      .DEPTH (DEPTH), .AW (AW), .SKID (SKID), .W (LP_EW)
   ) u_wr_q (
      .i_clk      (emesh_clk_inb),
      .i_rst      (reset),
      .i_push     (w_wr_push),
      .i_data     (w_wr_entry),
      .i_ready    (wr_ready),
      .o_valid    (wr_valid),
      .o_data     (w_wr_head),
      .o_wait     (emesh_wr_wait_outb),
      .o_overflow (wr_overflow)
   );

   ewrapper_emesh_rx_fifo #(
      .DEPTH (DEPTH), .AW (AW), .SKID (SKID), .W (LP_EW)
   ) u_rd_q (
      .i_clk      (emesh_clk_inb),
      .i_rst      (reset),
      .i_push     (w_rd_push),
      .i_data     (w_rd_entry),
      .i_ready    (rd_ready),
      .o_valid    (rd_valid),
      .o_data     (w_rd_head),
      .o_wait     (emesh_rd_wait_outb),
      .o_overflow (rd_overflow)
   );

   assign {wr_dstaddr, wr_data,    wr_datamode, wr_ctrlmode} = w_wr_head;
   assign {rd_dstaddr, rd_srcaddr, rd_datamode, rd_ctrlmode} = w_rd_head;

endmodule

// File: tb/tb_ewrapper_emesh_rx_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for ewrapper_emesh_rx_buffer.
// A queue-based model predicts what each head, valid, wait and overflow
// output should be. The outputs are compared against it on every falling
// edge. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_ewrapper_emesh_rx_buffer;

   localparam int DEPTH = 16;
   localparam int SKID  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        access = 1'b0;
   logic        write = 1'b0;
   logic [1:0]  dmode = '0;
   logic [3:0]  cmode = '0;
   logic [31:0] dst = '0;
   logic [31:0] src = '0;
   logic [31:0] data = '0;
   logic        wr_ready = 1'b0;
   logic        rd_ready = 1'b0;

   logic        wr_wait, rd_wait, wr_valid, rd_valid, wr_ovf, rd_ovf;
   logic [31:0] wr_dstaddr, wr_data, rd_dstaddr, rd_srcaddr;
   logic [1:0]  wr_datamode, rd_datamode;
   logic [3:0]  wr_ctrlmode, rd_ctrlmode;

   int n_tests = 0;
   int n_fail  = 0;

   ewrapper_emesh_rx_buffer #(.DEPTH(DEPTH), .AW(4), .SKID(SKID)) dut (
      .emesh_clk_inb      (clk),
      .reset              (rst),
      .emesh_access_inb   (access),
      .emesh_write_inb    (write),
      .emesh_datamode_inb (dmode),
      .emesh_ctrlmode_inb (cmode),
      .emesh_dstaddr_inb  (dst),
      .emesh_srcaddr_inb  (src),
      .emesh_data_inb     (data),
      .emesh_wr_wait_outb (wr_wait),
      .emesh_rd_wait_outb (rd_wait),
      .wr_valid           (wr_valid),
      .wr_ready           (wr_ready),
      .wr_dstaddr         (wr_dstaddr),
      .wr_data            (wr_data),
      .wr_datamode        (wr_datamode),
      .wr_ctrlmode        (wr_ctrlmode),
      .rd_valid           (rd_valid),
      .rd_ready           (rd_ready),
      .rd_dstaddr         (rd_dstaddr),
      .rd_srcaddr         (rd_srcaddr),
      .rd_datamode        (rd_datamode),
      .rd_ctrlmode        (rd_ctrlmode),
      .wr_overflow        (wr_ovf),
      .rd_overflow        (rd_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [69:0] m_wq[$];
   logic [69:0] m_rq[$];
   bit m_wr_wait = 1'b1, m_rd_wait = 1'b1, m_wr_ovf = 1'b0, m_rd_ovf = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_wq.delete();
         m_rq.delete();
         m_wr_wait = 1'b1;
         m_rd_wait = 1'b1;
         m_wr_ovf  = 1'b0;
         m_rd_ovf  = 1'b0;
      end else begin
         // The head leaves first, so a push to a full queue fits when a pop
         // happens in the same cycle.
         if (m_wq.size() > 0 && wr_ready) void'(m_wq.pop_front());
         if (m_rq.size() > 0 && rd_ready) void'(m_rq.pop_front());
         if (access && write) begin
            if (m_wq.size() < DEPTH) m_wq.push_back({dst, data, dmode, cmode});
            else m_wr_ovf = 1'b1;
         end
         if (access && !write) begin
            if (m_rq.size() < DEPTH) m_rq.push_back({dst, src, dmode, cmode});
            else m_rd_ovf = 1'b1;
         end
         m_wr_wait = (m_wq.size() >= DEPTH - SKID);
         m_rd_wait = (m_rq.size() >= DEPTH - SKID);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("wr_valid", wr_valid, m_wq.size() != 0);
      chk("rd_valid", rd_valid, m_rq.size() != 0);
      if (m_wq.size() != 0)
         chk("wr_head", {wr_dstaddr, wr_data, wr_datamode, wr_ctrlmode}, m_wq[0]);
      if (m_rq.size() != 0)
         chk("rd_head", {rd_dstaddr, rd_srcaddr, rd_datamode, rd_ctrlmode}, m_rq[0]);
      if (rst) begin
         chk("wr_head_rst", {wr_dstaddr, wr_data, wr_datamode, wr_ctrlmode}, '0);
         chk("rd_head_rst", {rd_dstaddr, rd_srcaddr, rd_datamode, rd_ctrlmode}, '0);
      end
      chk("wr_wait", wr_wait, m_wr_wait);
      chk("rd_wait", rd_wait, m_rd_wait);
      chk("wr_overflow", wr_ovf, m_wr_ovf);
      chk("rd_overflow", rd_ovf, m_rd_ovf);
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drives one access strobe for a single cycle. On return, the push edge
   // has just passed.
   task automatic push(input logic w, input logic [31:0] d, input logic [31:0] s,
                       input logic [31:0] a, input logic [1:0] dm, input logic [3:0] cm);
      access = 1'b1; write = w; dst = a; src = s; data = d; dmode = dm; cmode = cm;
      cyc();
      access = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      // Reset release with no traffic.
      cyc();
      cyc();
      chk("rst_wr_wait", wr_wait, 1'b1);
      chk("rst_rd_wait", rd_wait, 1'b1);
      rst = 1'b0;
      cyc();
      chk("rel_wr_wait", wr_wait, 1'b0);
      chk("rel_rd_wait", rd_wait, 1'b0);
      chk("rel_valids", {wr_valid, rd_valid, wr_ovf, rd_ovf}, 4'b0000);

      // Single write with the consumer ready.
      wr_ready = 1'b1;
      push(1'b1, 32'hDEADBEEF, 32'h0, 32'h8090_0000, 2'd2, 4'h0);
      chk("single_valid", wr_valid, 1'b1);
      chk("single_payload", {wr_dstaddr, wr_data, wr_datamode},
          {32'h8090_0000, 32'hDEADBEEF, 2'd2});
      chk("single_rd_untouched", rd_valid, 1'b0);
      cyc();
      chk("single_valid_drop", wr_valid, 1'b0);
      wr_ready = 1'b0;

      // Twelve writes reach the wait threshold.
      for (int i = 0; i < 12; i++) begin
         push(1'b1, 32'h100 + i, 32'h0, 32'h10 + i, 2'd1, 4'h1);
         if (i == 10) chk("wait_before_12", wr_wait, 1'b0);
         if (i == 11) begin
            chk("wait_after_12", wr_wait, 1'b1);
            chk("rd_wait_quiet", rd_wait, 1'b0);
         end
         cyc();
      end
      wr_ready = 1'b1;
      cyc();
      wr_ready = 1'b0;
      chk("wait_fall_after_pop", wr_wait, 1'b0);
      wr_ready = 1'b1;
      repeat (11) cyc();
      wr_ready = 1'b0;
      chk("drained_12", wr_valid, 1'b0);

      // Eighteen writes: sixteen are stored and the rest overflow.
      for (int i = 0; i < 18; i++) begin
         push(1'b1, 32'h1000 + i, 32'h0, 32'h2000 + i, 2'd3, 4'h2);
         if (i == 15) chk("no_ovf_at_16", wr_ovf, 1'b0);
         if (i == 16) chk("ovf_at_17", wr_ovf, 1'b1);
         cyc();
      end
      wr_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_order", {wr_valid, wr_data}, {1'b1, 32'h1000 + i});
         cyc();
      end
      chk("drain_no_extra", wr_valid, 1'b0);
      wr_ready = 1'b0;

      // Random interleaved traffic. The link honours wait, so no queue
      // should overflow.
      do_reset();
      for (int it = 0; it < 300; it++) begin
         wr_ready = ($urandom % 4) != 0;
         rd_ready = ($urandom % 4) != 0;
         if ($urandom % 3 != 0) begin
            logic w;
            w = $urandom % 2;
            if ((w && !wr_wait) || (!w && !rd_wait))
               access = 1'b1;
            write = w; dst = $urandom; src = $urandom; data = $urandom;
            dmode = 2'($urandom); cmode = 4'($urandom);
         end
         cyc();
         access = 1'b0;
         wr_ready = ($urandom % 4) != 0;
         rd_ready = ($urandom % 4) != 0;
         cyc();
      end
      wr_ready = 1'b1;
      rd_ready = 1'b1;
      repeat (20) cyc();
      chk("rand_no_ovf", {wr_ovf, rd_ovf}, 2'b00);
      chk("rand_drained", {wr_valid, rd_valid}, 2'b00);
      wr_ready = 1'b0;
      rd_ready = 1'b0;

      // Full queue: a push and a pop in the same cycle.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         push(1'b1, 32'h3000 + i, 32'h0, 32'h0, 2'd0, 4'h0);
         cyc();
      end
      chk("full_wait", {wr_wait, rd_wait}, 2'b10);
      wr_ready = 1'b1;
      push(1'b1, 32'h2222, 32'h0, 32'h0, 2'd0, 4'h0);
      wr_ready = 1'b0;
      chk("pushpop_no_ovf", wr_ovf, 1'b0);
      cyc();
      push(1'b1, 32'h4444, 32'h0, 32'h0, 2'd0, 4'h0);
      chk("still_full_ovf", wr_ovf, 1'b1);
      cyc();
      wr_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         chk("full_drain", {wr_valid, wr_data}, {1'b1, 32'h3000 + i});
         cyc();
      end
      chk("full_drain_last", {wr_valid, wr_data}, {1'b1, 32'h2222});
      cyc();
      chk("full_drain_empty", wr_valid, 1'b0);
      wr_ready = 1'b0;

      // Reset asserted in the middle of a cycle with five entries queued.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push(1'b1, 32'h5000 + i, 32'h0, 32'h0, 2'd1, 4'h3);
         cyc();
      end
      chk("five_queued", {wr_valid, wr_data}, {1'b1, 32'h5000});
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", wr_valid, 1'b0);
      chk("async_rst_wait", wr_wait, 1'b1);
      chk("async_rst_data", wr_data, 32'h0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("after_rst_empty", {wr_valid, wr_wait, wr_ovf}, 3'b000);
      repeat (3) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
